// File: rtl/ex_alu_stage_pkg.sv
// Shared constants for the execute stage: ALU operation codes as produced by decode.
package ex_alu_stage_pkg;

    localparam int unsigned AluOpW = 3;

    localparam logic [AluOpW-1:0] ALU_ADD = 3'b000;
    localparam logic [AluOpW-1:0] ALU_SUB = 3'b001;
    localparam logic [AluOpW-1:0] ALU_AND = 3'b010;
    localparam logic [AluOpW-1:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Purely combinational ALU datapath; unassigned opcodes fall back to ADD.
module alu_core
    import ex_alu_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [AluOpW-1:0] op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result
);

    // Wrap-around arithmetic; no carry/overflow is exported.
    always_comb begin
        result = a + b;
        case (op)
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU compute at accept, 2-entry skid buffer (main + skid) so in_ready is a
// flop and downstream stalls never reach decode combinationally.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AluOpW-1:0] in_alu_op,
    input  logic [XLEN-1:0]   in_src_a,
    input  logic [XLEN-1:0]   in_src_b,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_zero,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write
);

    // Occupancy: StOne = main slot only, StTwo = main + skid.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StTwo   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic              out_zero_q, out_zero_d;
    logic [RD_W-1:0]   out_rd_q, out_rd_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic [XLEN-1:0]   skid_result_q, skid_result_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic              skid_reg_write_q, skid_reg_write_d;

    logic [XLEN-1:0]   alu_result;
    logic              accept;
    logic              handoff;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .op     (in_alu_op),
        .a      (in_src_a),
        .b      (in_src_b),
        .result (alu_result)
    );

    assign accept  = in_valid & in_ready_q;
    assign handoff = out_valid_q & out_ready;

    // Next-state: slot movement, flush kill, and registered ready/valid/zero.
    always_comb begin
        state_d          = state_q;
        out_result_d     = out_result_q;
        out_rd_d         = out_rd_q;
        out_reg_write_d  = out_reg_write_q;
        skid_result_d    = skid_result_q;
        skid_rd_d        = skid_rd_q;
        skid_reg_write_d = skid_reg_write_q;

        if (flush) begin
            // Flush dominates any same-cycle accept or handoff.
            state_d         = StEmpty;
            out_reg_write_d = 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_result_d    = alu_result;
                        out_rd_d        = in_rd;
                        out_reg_write_d = in_reg_write;
                        state_d         = StOne;
                    end
                end
                StOne: begin
                    if (accept && handoff) begin
                        out_result_d    = alu_result;
                        out_rd_d        = in_rd;
                        out_reg_write_d = in_reg_write;
                    end else if (accept) begin
                        skid_result_d    = alu_result;
                        skid_rd_d        = in_rd;
                        skid_reg_write_d = in_reg_write;
                        state_d          = StTwo;
                    end else if (handoff) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (handoff) begin
                        out_result_d     = skid_result_q;
                        out_rd_d         = skid_rd_q;
                        out_reg_write_d  = skid_reg_write_q;
                        skid_reg_write_d = 1'b0;
                        state_d          = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        out_valid_d = (state_d != StEmpty);
        in_ready_d  = (state_d != StTwo);
        out_zero_d  = (out_result_d == '0);
    end

    // State and output registers; async reset drops every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StEmpty;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_zero_q       <= 1'b1;
            out_rd_q         <= '0;
            out_reg_write_q  <= 1'b0;
            skid_result_q    <= '0;
            skid_rd_q        <= '0;
            skid_reg_write_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_zero_q       <= out_zero_d;
            out_rd_q         <= out_rd_d;
            out_reg_write_q  <= out_reg_write_d;
            skid_result_q    <= skid_result_d;
            skid_rd_q        <= skid_rd_d;
            skid_reg_write_q <= skid_reg_write_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_zero      = out_zero_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_reg_write_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus a random stream checked
// against an in-order FIFO model holding at most two results.
module tb_ex_alu_stage;
    import ex_alu_stage_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_alu_op;
    logic [XLEN-1:0] in_src_a;
    logic [XLEN-1:0] in_src_b;
    logic [RD_W-1:0] in_rd;
    logic            in_reg_write;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [RD_W-1:0] out_rd;
    logic            out_reg_write;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            rw;
    } exp_t;

    exp_t model_q[$];

    ex_alu_stage #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_op     (in_alu_op),
        .in_src_a      (in_src_a),
        .in_src_b      (in_src_b),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [XLEN-1:0] ref_alu(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        if (op == ALU_SUB) return a - b;
        if (op == ALU_AND) return a & b;
        if (op == ALU_OR) return a | b;
        return a + b;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [RD_W-1:0] rd, input logic rw);
        in_valid     = 1'b1;
        in_alu_op    = op;
        in_src_a     = a;
        in_src_b     = b;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    // Advance one clock, updating the model from the inputs applied this cycle.
    task automatic step();
        exp_t e;
        bit   acc;
        bit   hs;
        acc = in_valid && (model_q.size() < 2);
        hs  = (model_q.size() > 0) && out_ready;
        e.result = ref_alu(in_alu_op, in_src_a, in_src_b);
        e.rd     = in_rd;
        e.rw     = in_reg_write;
        if (flush) begin
            model_q.delete();
        end else begin
            if (hs) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        checks++;
        if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", out_zero); end
        checks++;
        if (out_result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", out_result); end
        checks++;
        if (out_rd !== '0 || out_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_rw got %0d/%b exp 0/0", out_rd, out_reg_write);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [2:0]      ops[5];
        logic [XLEN-1:0] av[5];
        logic [XLEN-1:0] bv[5];
        logic [XLEN-1:0] ev[5];
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SUB};
        av  = '{32'd7, 32'd5, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd9};
        bv  = '{32'd5, 32'd7, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd9};
        ev  = '{32'd12, 32'hFFFF_FFFE, 32'h00F0_000F, 32'hFFF0_0FFF, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], av[i], bv[i], RD_W'(i + 3), i[0]);
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_result !== ev[i]) begin
                errors++;
                $display("FAIL ops_result[%0d] got %b/%h exp 1/%h", i, out_valid, out_result, ev[i]);
            end
            checks++;
            if (out_zero !== (i == 4)) begin
                errors++;
                $display("FAIL ops_zero[%0d] got %b exp %b", i, out_zero, (i == 4));
            end
            checks++;
            if (out_rd !== RD_W'(i + 3) || out_reg_write !== i[0]) begin
                errors++;
                $display("FAIL ops_fwd[%0d] got %0d/%b exp %0d/%b", i, out_rd, out_reg_write,
                         i + 3, i[0]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] got[$];
        int              expv[3];
        expv = '{2, 4, 30};
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
        step();
        drive(ALU_ADD, 32'd2, 32'd2, 5'd2, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd2) begin
            errors++;
            $display("FAIL bp_full got rdy=%b vld=%b res=%h exp 0/1/2", in_ready, out_valid, out_result);
        end
        drive(ALU_ADD, 32'd10, 32'd20, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_result !== 32'd2 || out_rd !== 5'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got rdy=%b res=%h rd=%0d exp 0/2/1", i, in_ready,
                         out_result, out_rd);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid && out_ready) got.push_back(out_result);
            if (in_valid && in_ready) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count got %0d exp 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== XLEN'(expv[i])) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got %0d exp %0d", i, got[i], expv[i]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic [XLEN-1:0] ev;
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            ev = ref_alu(op, a, b);
            drive(op, a, b, RD_W'(i), 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== ev) begin
                errors++;
                $display("FAIL stream[%0d] got vld=%b rdy=%b res=%h exp 1/1/%h", i, out_valid,
                         in_ready, out_result, ev);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        // Flush from TWO with an op presented.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd100, 32'd1, 5'd7, 1'b1);
        step();
        drive(ALU_ADD, 32'd200, 32'd2, 5'd8, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre got %b exp 0", in_ready); end
        drive(ALU_ADD, 32'd300, 32'd3, 5'd9, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_two got vld=%b rdy=%b rw=%b exp 0/1/0", out_valid, in_ready,
                     out_reg_write);
        end
        // Flush from ONE with a same-cycle accept that must be discarded.
        drive(ALU_ADD, 32'd40, 32'd1, 5'd4, 1'b1);
        step();
        drive(ALU_ADD, 32'd50, 32'd1, 5'd5, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost[%0d] got vld=%b res=%h exp 0", i, out_valid, out_result);
            end
            step();
        end
        drive(ALU_ADD, 32'd5, 32'd6, 5'd11, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd11 || out_rd !== 5'd11) begin
            errors++;
            $display("FAIL flush_after got vld=%b res=%0d rd=%0d exp 1/11/11", out_valid,
                     out_result, out_rd);
        end
        step();
    endtask

    task automatic test_unused_op();
        out_ready = 1'b1;
        for (int op = 4; op < 8; op++) begin
            drive(3'(op), 32'd3, 32'd4, 5'd1, 1'b0);
            step();
            checks++;
            if (out_result !== 32'd7) begin
                errors++;
                $display("FAIL unused_op[%0d] got %0d exp 7", op, out_result);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [XLEN-1:0] a;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs[%0d] got vld=%b rdy=%b exp occupancy %0d", i, out_valid,
                         in_ready, model_q.size());
            end
            if (model_q.size() > 0) begin
                checks++;
                if (out_result !== model_q[0].result || out_zero !== (model_q[0].result == '0) ||
                    out_rd !== model_q[0].rd || out_reg_write !== model_q[0].rw) begin
                    errors++;
                    $display("FAIL rand_data[%0d] got %h/%b/%0d/%b exp %h/%b/%0d/%b", i,
                             out_result, out_zero, out_rd, out_reg_write, model_q[0].result,
                             (model_q[0].result == '0), model_q[0].rd, model_q[0].rw);
                end
            end
            a = $urandom;
            drive(3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                  RD_W'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd8, 32'd8, 5'd2, 1'b1);
        step();
        drive(ALU_OR, 32'd1, 32'd2, 5'd3, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre got %b exp 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_hs got vld=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_zero !== 1'b1 || out_reg_write !== 1'b0 || out_result !== '0) begin
            errors++;
            $display("FAIL rstmid_data got z=%b rw=%b res=%h exp 1/0/0", out_zero, out_reg_write,
                     out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post got %b exp 0", out_valid); end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_alu_op    = '0;
        in_src_a     = '0;
        in_src_b     = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ops();
        test_backpressure();
        test_streaming();
        test_flush();
        test_unused_op();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
